shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational shift unit (SLL/SRL/SRA, 32-bit) between two requesters. It accepts one request at a time over a valid/ready handshake and drives the operands into the shared shifter. It captures the shifter output into a result register and returns it on the granted requester's response channel. It sits between the ALU issue logic and the single shifter instance, and also keeps per-requester grant counters for debug.

---
 rtl/shift_arbiter_if.sv | 43 ++++
 rtl/shift_arbiter.sv | 140 ++++++++++++++
 tb/tb_shift_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Bundle of request/response channels, shared-shifter operands and debug counters
// for shift_arbiter. The master side is the requesters plus the shifter instance.
interface shift_arbiter_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
);
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [1:0]       req0_op;
  logic [1:0]       req1_op;
  logic [N-1:0]     req0_x;
  logic [N-1:0]     req1_x;
  logic [N-1:0]     req0_y;
  logic [N-1:0]     req1_y;
  logic             resp0_valid;
  logic             resp1_valid;
  logic             resp0_ready;
  logic             resp1_ready;
  logic [N-1:0]     resp_data;
  logic             resp_err;
  logic [1:0]       sh_op;
  logic [N-1:0]     sh_x;
  logic [N-1:0]     sh_y;
  logic [N-1:0]     sh_z;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_x, req1_x, req0_y, req1_y,
    output resp0_ready, resp1_ready, sh_z,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_err,
    input  sh_op, sh_x, sh_y, gnt_cnt0, gnt_cnt1
  );

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_x, req1_x, req0_y, req1_y,
    input  resp0_ready, resp1_ready, sh_z,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_err,
    output sh_op, sh_x, sh_y, gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter/sequencer sharing one 32-bit shift unit between two requesters,
// one transaction in flight, with saturating per-requester grant counters.
module shift_arbiter #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           rstb,
  shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [1:0]       op_q, op_d;
  logic [N-1:0]     x_q, x_d;
  logic [N-1:0]     y_q, y_d;
  logic [N-1:0]     data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic gnt_valid;
  logic gnt_id;

  // Grant exists only in IDLE; on a tie the requester that did not win last time wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_q;
      end else if (bus.req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (bus.req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_q ? bus.resp1_ready : bus.resp0_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req0_ready = gnt_valid && !gnt_id;
        bus.req1_ready = gnt_valid && gnt_id;
      end
      RESP: begin
        bus.resp0_valid = !owner_q;
        bus.resp1_valid = owner_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (gnt_valid) begin
      owner_d = gnt_id;
      last_d  = gnt_id;
      op_d    = gnt_id ? bus.req1_op : bus.req0_op;
      x_d     = gnt_id ? bus.req1_x  : bus.req0_x;
      y_d     = gnt_id ? bus.req1_y  : bus.req0_y;
      if (!gnt_id && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
      if (gnt_id && (cnt1_q != '1))  cnt1_d = cnt1_q + CNT_W'(1);
    end
    // Illegal op bypasses the shifter and echoes the operand back with the error flag.
    if (state_q == EXEC) begin
      data_d = (op_q == 2'b11) ? x_q : bus.sh_z;
      err_d  = (op_q == 2'b11);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.sh_op     = op_q;
  assign bus.sh_x      = x_q;
  assign bus.sh_y      = y_q;
  assign bus.resp_data = data_q;
  assign bus.resp_err  = err_q;
  assign bus.gnt_cnt0  = cnt0_q;
  assign bus.gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model (one in flight, round-robin tie break, saturating counts).
module tb_shift_arbiter;
  localparam int unsigned N  = 32;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  shift_arbiter_if #(.N(N), .CNT_W(CW)) bus ();
  shift_arbiter #(.N(N), .CNT_W(CW)) dut (.clk(clk), .rstb(rstb), .bus(bus));

  logic        drv_valid [2];
  logic [1:0]  drv_op    [2];
  logic [31:0] drv_x     [2];
  logic [31:0] drv_y     [2];
  logic        resp_rdy  [2];

  assign bus.req0_valid  = drv_valid[0];
  assign bus.req1_valid  = drv_valid[1];
  assign bus.req0_op     = drv_op[0];
  assign bus.req1_op     = drv_op[1];
  assign bus.req0_x      = drv_x[0];
  assign bus.req1_x      = drv_x[1];
  assign bus.req0_y      = drv_y[0];
  assign bus.req1_y      = drv_y[1];
  assign bus.resp0_ready = resp_rdy[0];
  assign bus.resp1_ready = resp_rdy[1];

  // Shared shift unit as the environment provides it; op 11 yields garbage on purpose.
  logic [63:0] sra_ext;
  assign sra_ext = {{32{bus.sh_x[31]}}, bus.sh_x} >> bus.sh_y[4:0];
  always_comb begin
    bus.sh_z = '0;
    case (bus.sh_op)
      2'b00:   bus.sh_z = (bus.sh_y > 31) ? '0 : bus.sh_x << bus.sh_y[4:0];
      2'b01:   bus.sh_z = (bus.sh_y > 31) ? '0 : bus.sh_x >> bus.sh_y[4:0];
      2'b10:   bus.sh_z = (bus.sh_y > 31) ? {32{bus.sh_x[31]}} : sra_ext[31:0];
      default: bus.sh_z = bus.sh_x ^ 32'hA5A5_5A5A;
    endcase
  end

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
    case (op)
      2'b00:   return x << y;
      2'b01:   return x >> y;
      2'b10:   return 32'($signed(x) >>> y);
      default: return x;
    endcase
  endfunction

  typedef struct {
    bit          who;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          age = 0;
  int          n_acc = 0;
  int          acc_cnt [2] = '{0, 0};
  int          acc_t[$];
  bit          acc_who[$];
  int          hs_cyc = -1;
  logic [31:0] hs_data = '0;
  bit          hs_err = 1'b0;
  bit          hs_who = 1'b0;
  bit          last_g = 1'b1;
  int unsigned m_cnt [2] = '{0, 0};
  bit          eg_v, eg, ev_any;
  exp_t        e;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at t=%0t", name, $time);
  endfunction

  function automatic void check_zero(input string tag);
    chk({tag, "_req0_ready"}, 32'(bus.req0_ready), 0);
    chk({tag, "_req1_ready"}, 32'(bus.req1_ready), 0);
    chk({tag, "_resp0_valid"}, 32'(bus.resp0_valid), 0);
    chk({tag, "_resp1_valid"}, 32'(bus.resp1_valid), 0);
    chk({tag, "_resp_data"}, bus.resp_data, 0);
    chk({tag, "_resp_err"}, 32'(bus.resp_err), 0);
    chk({tag, "_sh_op"}, 32'(bus.sh_op), 0);
    chk({tag, "_sh_x"}, bus.sh_x, 0);
    chk({tag, "_sh_y"}, bus.sh_y, 0);
    chk({tag, "_gnt_cnt0"}, 32'(bus.gnt_cnt0), 0);
    chk({tag, "_gnt_cnt1"}, 32'(bus.gnt_cnt1), 0);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: all expectations use the model state as it stood before this cycle's edge.
  always @(negedge clk) begin
    if (!rstb) begin
      q.delete();
      last_g = 1'b1;
      m_cnt  = '{0, 0};
      age    = 0;
    end else begin
      if (q.size() > 0) age++;
      eg_v = 1'b0;
      eg   = 1'b0;
      if (q.size() == 0) begin
        eg_v = drv_valid[0] || drv_valid[1];
        eg   = (drv_valid[0] && drv_valid[1]) ? ~last_g : !drv_valid[0];
      end
      chk("req0_ready", 32'(bus.req0_ready), 32'(eg_v && !eg));
      chk("req1_ready", 32'(bus.req1_ready), 32'(eg_v && eg));
      ev_any = (q.size() > 0) && (age >= 2);
      chk("resp0_valid", 32'(bus.resp0_valid), 32'(ev_any && !q[0].who));
      chk("resp1_valid", 32'(bus.resp1_valid), 32'(ev_any && q[0].who));
      if (q.size() > 0) begin
        chk("sh_op", 32'(bus.sh_op), 32'(q[0].op));
        chk("sh_x", bus.sh_x, q[0].x);
        chk("sh_y", bus.sh_y, q[0].y);
      end
      if (ev_any) begin
        chk("resp_data", bus.resp_data, q[0].data);
        chk("resp_err", 32'(bus.resp_err), 32'(q[0].err));
      end
      chk("gnt_cnt0", 32'(bus.gnt_cnt0), m_cnt[0]);
      chk("gnt_cnt1", 32'(bus.gnt_cnt1), m_cnt[1]);
      if (ev_any && resp_rdy[q[0].who]) begin
        hs_cyc  = cyc;
        hs_data = bus.resp_data;
        hs_err  = bus.resp_err;
        hs_who  = q[0].who;
        void'(q.pop_front());
      end
      if (eg_v) begin
        e.who  = eg;
        e.op   = drv_op[eg];
        e.x    = drv_x[eg];
        e.y    = drv_y[eg];
        e.data = ref_result(drv_op[eg], drv_x[eg], drv_y[eg]);
        e.err  = (drv_op[eg] == 2'b11);
        q.push_back(e);
        age    = 0;
        last_g = eg;
        if (m_cnt[eg] < (32'd1 << CW) - 1) m_cnt[eg]++;
        acc_cnt[eg]++;
        acc_t.push_back(cyc);
        acc_who.push_back(eg);
        n_acc++;
      end
    end
  end

  task automatic issue(input int k, input logic [1:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    int start;
    start = acc_cnt[k];
    @(posedge clk); #1;
    drv_valid[k] = 1'b1;
    drv_op[k]    = op;
    drv_x[k]     = x;
    drv_y[k]     = y;
    for (int i = 0; i < 60 && acc_cnt[k] == start; i++) @(negedge clk);
    if (acc_cnt[k] == start) timeout("issue_accept");
    @(posedge clk); #1;
    drv_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) timeout("drain");
  endtask

  task automatic tie_until(input int count);
    int start;
    start = n_acc;
    @(posedge clk); #1;
    drv_valid[0] = 1'b1; drv_op[0] = 2'b00; drv_x[0] = 32'h0000_0003; drv_y[0] = 32'd1;
    drv_valid[1] = 1'b1; drv_op[1] = 2'b01; drv_x[1] = 32'h0000_0100; drv_y[1] = 32'd4;
    for (int i = 0; i < 80 && n_acc < start + count; i++) @(negedge clk);
    if (n_acc < start + count) timeout("tie_accepts");
    @(posedge clk); #1;
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
  endtask

  initial begin
    int s;
    bit a0, a1;
    for (int k = 0; k < 2; k++) begin
      drv_valid[k] = 1'b0; drv_op[k] = '0; drv_x[k] = '0; drv_y[k] = '0; resp_rdy[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1 check_zero("por");
    @(posedge clk); #3 rstb = 1'b1;

    issue(0, 2'b00, 32'h0000_0001, 32'd4);
    wait_idle();
    chk("sll_data", hs_data, 32'h0000_0010);
    chk("sll_err", 32'(hs_err), 0);
    chk("sll_cnt0", 32'(bus.gnt_cnt0), 1);

    issue(1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0020);
    wait_idle();
    chk("big_shift_data", hs_data, 32'h0);
    issue(1, 2'b10, 32'h8000_0000, 32'd4);
    wait_idle();
    chk("sra_data", hs_data, 32'hF800_0000);
    chk("sra_owner", 32'(hs_who), 1);

    s = n_acc;
    tie_until(4);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      chk("tie_order", 32'(acc_who[s + i]), 32'(i % 2));
      if (i > 0) chk("tie_spacing", 32'(acc_t[s + i] - acc_t[s + i - 1]), 3);
    end
    chk("tie_cnt0", 32'(bus.gnt_cnt0), 3);
    chk("tie_cnt1", 32'(bus.gnt_cnt1), 4);

    resp_rdy[0] = 1'b0;
    issue(0, 2'b01, 32'hF000_0000, 32'd8);
    drv_valid[1] = 1'b1; drv_op[1] = 2'b00; drv_x[1] = 32'h1; drv_y[1] = 32'd31;
    s = acc_cnt[1];
    for (int i = 0; i < 10 && !bus.resp0_valid; i++) @(negedge clk);
    if (!bus.resp0_valid) timeout("bp_resp_valid");
    repeat (5) @(negedge clk);
    @(posedge clk); #1 resp_rdy[0] = 1'b1;
    for (int i = 0; i < 10 && acc_cnt[1] == s; i++) @(negedge clk);
    if (acc_cnt[1] == s) timeout("bp_req1_accept");
    else chk("bp_accept_gap", 32'(acc_t[acc_t.size() - 1] - hs_cyc), 1);
    @(posedge clk); #1 drv_valid[1] = 1'b0;
    wait_idle();

    issue(0, 2'b11, 32'h1234_5678, 32'd5);
    wait_idle();
    chk("illegal_data", hs_data, 32'h1234_5678);
    chk("illegal_err", 32'(hs_err), 1);
    issue(0, 2'b00, 32'h0000_00FF, 32'd8);
    wait_idle();
    chk("legal_after_err", 32'(hs_err), 0);
    chk("legal_after_data", hs_data, 32'h0000_FF00);

    issue(0, 2'b01, 32'h0000_FFFF, 32'd2);
    #2 rstb = 1'b0;
    #1 check_zero("mid_rst");
    repeat (2) @(posedge clk);
    #3 rstb = 1'b1;
    s = n_acc;
    tie_until(1);
    wait_idle();
    chk("post_rst_grant", 32'(acc_who[s]), 0);

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      a0 = drv_valid[0] && bus.req0_ready;
      a1 = drv_valid[1] && bus.req1_ready;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (!drv_valid[k] || (k == 0 ? a0 : a1)) begin
          drv_valid[k] = ($urandom_range(0, 2) != 0);
          drv_op[k]    = 2'($urandom_range(0, 3));
          drv_x[k]     = $urandom;
          drv_y[k]     = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
        end
        resp_rdy[k] = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk); #1;
    drv_valid[0] = 1'b0; drv_valid[1] = 1'b0;
    resp_rdy[0] = 1'b1;  resp_rdy[1] = 1'b1;
    wait_idle();
    chk("sat_cnt0", 32'(bus.gnt_cnt0), 7);
    chk("sat_cnt1", 32'(bus.gnt_cnt1), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
